// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation
// encoding, controller states and the default datapath width.
package muldiv_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_DIV_RUN = 2'b10,
        ST_DONE    = 2'b11
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iteration_unit.sv
// One combinational iteration of the unsigned multiply/divide datapath.
// The accumulator is {hi, lo}: product high/multiplier, or remainder/quotient.
module muldiv_iteration_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   acc_in,
    input  logic [DATA_WIDTH-1:0]     operand,
    output logic [2*DATA_WIDTH-1:0]   acc_out
);

    logic [DATA_WIDTH-1:0] acc_hi;
    logic [DATA_WIDTH-1:0] acc_lo;
    logic [DATA_WIDTH:0]   add_term;
    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   shifted_rem;
    logic [DATA_WIDTH:0]   sub_diff;

    assign acc_hi = acc_in[2*DATA_WIDTH-1:DATA_WIDTH];
    assign acc_lo = acc_in[DATA_WIDTH-1:0];

    // Shift-add: conditionally add the multiplicand into the high half,
    // then shift the whole accumulator right keeping the carry.
    assign add_term = acc_lo[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}};
    assign add_sum  = {1'b0, acc_hi} + add_term;

    // Restoring divide: the remainder stays below the divisor, so the
    // shifted value fits in DATA_WIDTH+1 bits and the top bit of the
    // difference is the borrow.
    assign shifted_rem = {acc_hi, acc_lo[DATA_WIDTH-1]};
    assign sub_diff    = shifted_rem - {1'b0, operand};

    // NOTE: acc_out gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        acc_out = {add_sum, acc_lo[DATA_WIDTH-1:1]};
        if (is_div) begin
            if (!sub_diff[DATA_WIDTH]) begin
                acc_out = {sub_diff[DATA_WIDTH-1:0], acc_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {shifted_rem[DATA_WIDTH-1:0], acc_lo[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hi_lo_muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide controller: runs a 32-step shift-add or
// restoring divide, pulses the HI/LO write strobes and stalls HI/LO readers.
module hi_lo_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int ITERATIONS  = DATA_WIDTH,
    parameter int COUNT_WIDTH = $clog2(ITERATIONS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  hi_lo_read_decode,
    output logic                  busy,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  clear_execute,
    output logic                  HI_register_write,
    output logic                  LO_register_write,
    output logic [DATA_WIDTH-1:0] hi_result,
    output logic [DATA_WIDTH-1:0] lo_result,
    output logic                  div_by_zero
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(ITERATIONS - 1);

    muldiv_state_e           state_q, state_d;
    logic [COUNT_WIDTH-1:0]  counter_q, counter_d;
    logic                    is_div_q, is_div_d;
    logic                    sign_a_q, sign_a_d;
    logic                    sign_b_q, sign_b_d;
    logic                    dbz_q, dbz_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   operand_q, operand_d;
    logic [DATA_WIDTH-1:0]   hi_hold_q, hi_hold_d;
    logic [DATA_WIDTH-1:0]   lo_hold_q, lo_hold_d;

    muldiv_op_e              op_in;
    logic                    neg_a;
    logic                    neg_b;
    logic [DATA_WIDTH-1:0]   abs_a;
    logic [DATA_WIDTH-1:0]   abs_b;
    logic [2*DATA_WIDTH-1:0] acc_step;
    logic [DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]   remainder;
    logic [2*DATA_WIDTH-1:0] product_neg;
    logic [DATA_WIDTH-1:0]   hi_final;
    logic [DATA_WIDTH-1:0]   lo_final;

    assign op_in = muldiv_op_e'(op);
    assign neg_a = op_is_signed(op_in) && operand_a[DATA_WIDTH-1];
    assign neg_b = op_is_signed(op_in) && operand_b[DATA_WIDTH-1];
    assign abs_a = neg_a ? (~operand_a + 1'b1) : operand_a;
    assign abs_b = neg_b ? (~operand_b + 1'b1) : operand_b;

    muldiv_iteration_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iteration (
        .is_div  (state_q == ST_DIV_RUN),
        .acc_in  (acc_q),
        .operand (operand_q),
        .acc_out (acc_step)
    );

    // Sign correction of the unsigned magnitude result, applied in DONE.
    // A divide by zero bypasses it and presents the raw dividend/all-ones.
    assign quotient    = acc_q[DATA_WIDTH-1:0];
    assign remainder   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign product_neg = ~acc_q + 1'b1;

    always_comb begin
        hi_final = remainder;
        lo_final = quotient;
        if (dbz_q) begin
            hi_final = remainder;
            lo_final = quotient;
        end else if (is_div_q) begin
            lo_final = (sign_a_q ^ sign_b_q) ? (~quotient + 1'b1) : quotient;
            hi_final = sign_a_q ? (~remainder + 1'b1) : remainder;
        end else if (sign_a_q ^ sign_b_q) begin
            hi_final = product_neg[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_final = product_neg[DATA_WIDTH-1:0];
        end
    end

    assign hi_result = (state_q == ST_DONE) ? hi_final : hi_hold_q;
    assign lo_result = (state_q == ST_DONE) ? lo_final : lo_hold_q;
    assign hi_hold_d = hi_result;
    assign lo_hold_d = lo_result;

    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        is_div_d          = is_div_q;
        sign_a_d          = sign_a_q;
        sign_b_d          = sign_b_q;
        dbz_d             = dbz_q;
        acc_d             = acc_q;
        operand_d         = operand_q;
        busy              = (state_q != ST_IDLE);
        HI_register_write = 1'b0;
        LO_register_write = 1'b0;
        div_by_zero       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d  = op_is_div(op_in);
                    sign_a_d  = neg_a;
                    sign_b_d  = neg_b;
                    counter_d = '0;
                    dbz_d     = 1'b0;
                    if (op_is_div(op_in) && (operand_b == '0)) begin
                        dbz_d    = 1'b1;
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                        acc_d    = {operand_a, {DATA_WIDTH{1'b1}}};
                        state_d  = ST_DONE;
                    end else if (op_is_div(op_in)) begin
                        acc_d     = {{DATA_WIDTH{1'b0}}, abs_a};
                        operand_d = abs_b;
                        state_d   = ST_DIV_RUN;
                    end else begin
                        acc_d     = {{DATA_WIDTH{1'b0}}, abs_b};
                        operand_d = abs_a;
                        state_d   = ST_MUL_RUN;
                    end
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                acc_d     = acc_step;
                counter_d = counter_q + 1'b1;
                if (counter_q == LAST_COUNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                HI_register_write = 1'b1;
                LO_register_write = 1'b1;
                div_by_zero       = dbz_q;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // HI/LO are written at the end of DONE, so readers stall through it too.
    assign stall_fetch   = hi_lo_read_decode && (state_q != ST_IDLE);
    assign stall_decode  = stall_fetch;
    assign clear_execute = stall_fetch;

    // NOTE: flops use <= so every register samples the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are reset as well, so an aborted operation leaves no partial result on hi/lo_result.
            state_q   <= ST_IDLE;
            counter_q <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            operand_q <= '0;
            hi_hold_q <= '0;
            lo_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            dbz_q     <= dbz_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            hi_hold_q <= hi_hold_d;
            lo_hold_q <= lo_hold_d;
        end
    end

endmodule
